// File: rtl/core_types_pkg.sv
// Shared core widths and counts for the rename free list.
// Also carries the enqueue buffer sizing used by the free list write side.
package core_types_pkg;
  localparam int FREE_LIST_BANK_COUNT = 4;
  localparam int LOG_FREE_LIST_BANK_COUNT = 2;
  localparam int LOG_PR_COUNT = 7;
  localparam int FREE_LIST_ENQ_PORT_COUNT = 4;
  localparam int FREE_LIST_ENQ_BUFFER_DEPTH = 8;
  localparam int LOG_FREE_LIST_ENQ_BUFFER_DEPTH = 3;

  typedef logic [LOG_PR_COUNT-1:0] pr_tag_t;
  typedef logic [LOG_FREE_LIST_ENQ_BUFFER_DEPTH-1:0] fl_ptr_t;
  typedef logic [LOG_FREE_LIST_ENQ_BUFFER_DEPTH:0] fl_cnt_t;
endpackage

// File: rtl/free_list_enq_bank_fifo.sv
// Per-bank circular FIFO: up to PORT_COUNT writes per cycle at tail+offset,
// one read per cycle from head over valid/ready.
module free_list_enq_bank_fifo
  import core_types_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic [FREE_LIST_ENQ_PORT_COUNT-1:0] wr_en,
  input  fl_ptr_t [FREE_LIST_ENQ_PORT_COUNT-1:0] wr_offset,
  input  pr_tag_t [FREE_LIST_ENQ_PORT_COUNT-1:0] wr_PR,
  input  fl_cnt_t n_enq,
  input  logic deq_ready,
  output logic deq_valid,
  output pr_tag_t deq_PR,
  output fl_cnt_t count
);
  localparam int D = FREE_LIST_ENQ_BUFFER_DEPTH;

  pr_tag_t mem [D];
  fl_ptr_t head;
  fl_ptr_t tail;
  logic fire;

  assign deq_valid = (count != '0);
  assign deq_PR = deq_valid ? mem[head] : '0;
  assign fire = deq_valid & deq_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + fl_ptr_t'(fire);
      tail <= tail + n_enq[LOG_FREE_LIST_ENQ_BUFFER_DEPTH-1:0];
      count <= count + n_enq - fl_cnt_t'(fire);
    end
  end

  // Storage is not reset; deq_PR is masked while empty.
  always_ff @(posedge CLK) begin
    for (int p = 0; p < FREE_LIST_ENQ_PORT_COUNT; p++) begin
      if (wr_en[p]) mem[fl_ptr_t'(tail + wr_offset[p])] <= wr_PR[p];
    end
  end

  a_no_overflow: assert property (
    @(posedge CLK) disable iff (RST) count <= fl_cnt_t'(D)
  );
endmodule

// File: rtl/free_list_enq_buffer.sv
// Free list write side: steers freed PRs to per-bank FIFOs by PR low bits
// and drains one PR per bank per cycle.
module free_list_enq_buffer
  import core_types_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic [FREE_LIST_ENQ_PORT_COUNT-1:0] enq_valid_by_port,
  input  pr_tag_t [FREE_LIST_ENQ_PORT_COUNT-1:0] enq_PR_by_port,
  output logic enq_ready,
  output logic [FREE_LIST_BANK_COUNT-1:0] deq_valid_by_bank,
  output pr_tag_t [FREE_LIST_BANK_COUNT-1:0] deq_PR_by_bank,
  input  logic [FREE_LIST_BANK_COUNT-1:0] deq_ready_by_bank
);
  localparam int B = FREE_LIST_BANK_COUNT;
  localparam int P = FREE_LIST_ENQ_PORT_COUNT;
  localparam int LB = LOG_FREE_LIST_BANK_COUNT;
  localparam fl_cnt_t READY_MAX =
    fl_cnt_t'(FREE_LIST_ENQ_BUFFER_DEPTH - FREE_LIST_ENQ_PORT_COUNT);

  logic [B-1:0][P-1:0] mask;
  fl_ptr_t [B-1:0][P-1:0] offset;
  fl_cnt_t [B-1:0] n_enq;
  fl_cnt_t [B-1:0] count;

  // Space for a full port burst in every bank, from registered counts only.
  always_comb begin
    enq_ready = 1'b1;
    for (int b = 0; b < B; b++) begin
      if (count[b] > READY_MAX) enq_ready = 1'b0;
    end
  end

  // Prefix count gives each same-bank port its slot after tail.
  always_comb begin
    mask = '0;
    offset = '0;
    n_enq = '0;
    for (int b = 0; b < B; b++) begin
      for (int p = 0; p < P; p++) begin
        mask[b][p] = enq_ready & enq_valid_by_port[p] &
          (enq_PR_by_port[p][LB-1:0] == LB'(b));
        offset[b][p] = n_enq[b][LOG_FREE_LIST_ENQ_BUFFER_DEPTH-1:0];
        n_enq[b] = n_enq[b] + fl_cnt_t'(mask[b][p]);
      end
    end
  end

  for (genvar b = 0; b < B; b++) begin : g_bank
    free_list_enq_bank_fifo u_fifo (
      .CLK(CLK),
      .RST(RST),
      .wr_en(mask[b]),
      .wr_offset(offset[b]),
      .wr_PR(enq_PR_by_port),
      .n_enq(n_enq[b]),
      .deq_ready(deq_ready_by_bank[b]),
      .deq_valid(deq_valid_by_bank[b]),
      .deq_PR(deq_PR_by_bank[b]),
      .count(count[b])
    );
  end
endmodule

// File: tb/tb_free_list_enq_buffer.sv
// Directed bench for free_list_enq_buffer with hand-computed expectations.
module tb_free_list_enq_buffer;
  import core_types_pkg::*;

  logic CLK;
  logic RST;
  logic [3:0] enq_valid_by_port;
  pr_tag_t [3:0] enq_PR_by_port;
  logic enq_ready;
  logic [3:0] deq_valid_by_bank;
  pr_tag_t [3:0] deq_PR_by_bank;
  logic [3:0] deq_ready_by_bank;

  int errs;
  int n_checks;

  free_list_enq_buffer dut (
    .CLK(CLK),
    .RST(RST),
    .enq_valid_by_port(enq_valid_by_port),
    .enq_PR_by_port(enq_PR_by_port),
    .enq_ready(enq_ready),
    .deq_valid_by_bank(deq_valid_by_bank),
    .deq_PR_by_bank(deq_PR_by_bank),
    .deq_ready_by_bank(deq_ready_by_bank)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input int p0, input int p1,
                       input int p2, input int p3);
    enq_valid_by_port = v;
    enq_PR_by_port[0] = pr_tag_t'(p0);
    enq_PR_by_port[1] = pr_tag_t'(p1);
    enq_PR_by_port[2] = pr_tag_t'(p2);
    enq_PR_by_port[3] = pr_tag_t'(p3);
  endtask

  task automatic idle();
    drive(4'b0000, 0, 0, 0, 0);
  endtask

  initial begin
    int exp_b0 [4];
    errs = 0;
    n_checks = 0;
    exp_b0 = '{0, 4, 8, 12};
    RST = 1'b1;
    idle();
    deq_ready_by_bank = 4'h0;
    #12;
    check("rst_valid", 32'(deq_valid_by_bank), 32'h0);
    check("rst_pr", 32'(deq_PR_by_bank), 32'h0);
    check("rst_ready", 32'(enq_ready), 32'h1);
    step();
    RST = 1'b0;
    step();

    // Mid-stream reset with bank 1 holding 5 PRs
    drive(4'b1111, 1, 5, 9, 13);
    step();
    drive(4'b0001, 17, 0, 0, 0);
    step();
    idle();
    check("pre_rst_v1", 32'(deq_valid_by_bank), 32'h2);
    check("pre_rst_rdy", 32'(enq_ready), 32'h0);
    #2;
    RST = 1'b1;
    #1;
    check("mid_rst_valid", 32'(deq_valid_by_bank), 32'h0);
    check("mid_rst_ready", 32'(enq_ready), 32'h1);
    step();
    RST = 1'b0;
    step();
    check("post_rst_valid", 32'(deq_valid_by_bank), 32'h0);

    // Same-bank burst into bank 2
    deq_ready_by_bank = 4'hF;
    drive(4'b1111, 2, 6, 10, 14);
    step();
    idle();
    for (int i = 0; i < 4; i++) begin
      check("burst_valid", 32'(deq_valid_by_bank), 32'h4);
      check("burst_pr", 32'(deq_PR_by_bank[2]), 32'(2 + 4 * i));
      step();
    end
    check("burst_empty", 32'(deq_valid_by_bank), 32'h0);

    // Backpressure on bank 0
    deq_ready_by_bank = 4'h0;
    drive(4'b1111, 0, 4, 8, 12);
    step();
    check("bp_rdy_half", 32'(enq_ready), 32'h1);
    step();
    check("bp_rdy_full", 32'(enq_ready), 32'h0);
    drive(4'b1111, 16, 20, 24, 28);
    step();
    idle();
    check("bp_rdy_hold", 32'(enq_ready), 32'h0);
    deq_ready_by_bank = 4'h1;
    for (int i = 0; i < 4; i++) begin
      check("bp_rdy_drain", 32'(enq_ready), 32'h0);
      check("bp_pr_a", 32'(deq_PR_by_bank[0]), 32'(exp_b0[i]));
      step();
    end
    check("bp_rdy_back", 32'(enq_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("bp_pr_b", 32'(deq_PR_by_bank[0]), 32'(exp_b0[i]));
      step();
    end
    check("bp_empty", 32'(deq_valid_by_bank), 32'h0);

    // Pointer wrap on bank 3
    deq_ready_by_bank = 4'h8;
    for (int k = 0; k < 20; k++) begin
      drive(4'b0001, 3 + 4 * k, 0, 0, 0);
      if (k > 0) check("wrap_pr", 32'(deq_PR_by_bank[3]), 32'(3 + 4 * (k - 1)));
      step();
    end
    idle();
    check("wrap_last", 32'(deq_PR_by_bank[3]), 32'd79);
    step();
    check("wrap_empty", 32'(deq_valid_by_bank), 32'h0);

    // Simultaneous enqueue and dequeue on bank 1
    deq_ready_by_bank = 4'h0;
    drive(4'b0001, 5, 0, 0, 0);
    step();
    check("sim_v0", 32'(deq_valid_by_bank), 32'h2);
    check("sim_pr0", 32'(deq_PR_by_bank[1]), 32'd5);
    drive(4'b0001, 9, 0, 0, 0);
    deq_ready_by_bank = 4'h2;
    step();
    idle();
    deq_ready_by_bank = 4'h0;
    check("sim_v1", 32'(deq_valid_by_bank), 32'h2);
    check("sim_pr1", 32'(deq_PR_by_bank[1]), 32'd9);
    deq_ready_by_bank = 4'h2;
    step();
    check("sim_empty", 32'(deq_valid_by_bank), 32'h0);

    // Enqueue into empty bank with deq_ready high: nothing fires
    deq_ready_by_bank = 4'hF;
    drive(4'b0001, 21, 0, 0, 0);
    check("nobyp_v", 32'(deq_valid_by_bank), 32'h0);
    step();
    idle();
    check("nobyp_pr", 32'(deq_PR_by_bank[1]), 32'd21);
    step();

    // Sparse ports 1 and 3 into bank 3
    drive(4'b1010, 3, 7, 15, 11);
    step();
    idle();
    check("sparse_pr0", 32'(deq_PR_by_bank[3]), 32'd7);
    step();
    check("sparse_pr1", 32'(deq_PR_by_bank[3]), 32'd11);
    step();
    check("sparse_empty", 32'(deq_valid_by_bank), 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, n_checks);
    $finish;
  end
endmodule
